// File: rtl/alu_pkg.sv
// Shared definitions for the 10-bit ALU and its 11-bit adder datapath core.
package alu_pkg;

    // Adder width: 10-bit ALU operands sign-extended by one bit so that
    // add/subtract results never overflow the adder.
    localparam int ALU_DATA_WIDTH = 10;
    localparam int ALU_ADD_WIDTH  = ALU_DATA_WIDTH + 1;

    // ALU operation codes.
    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'b00,
        ALU_OP_SUB = 2'b01,
        ALU_OP_EQ  = 2'b10,
        ALU_OP_LT  = 2'b11
    } alu_op_e;

    // Operands as presented to the adder after ALU operand conditioning.
    typedef struct packed {
        logic [ALU_ADD_WIDTH-1:0] a;
        logic [ALU_ADD_WIDTH-1:0] b;
        logic                     cin;
    } alu_add_req_t;

    // Registered adder result.
    typedef struct packed {
        logic                     cout;
        logic [ALU_ADD_WIDTH-1:0] sum;
    } alu_add_rsp_t;

    // Sign-extend a 10-bit ALU operand to the adder width.
    function automatic logic [ALU_ADD_WIDTH-1:0] alu_sext(
        input logic [ALU_DATA_WIDTH-1:0] v
    );
        return {v[ALU_DATA_WIDTH-1], v};
    endfunction

    // Build the adder request for an op: subtract and compares invert b and
    // inject a carry so the adder computes a - b.
    function automatic alu_add_req_t alu_add_req(
        input alu_op_e                   op,
        input logic [ALU_DATA_WIDTH-1:0] a,
        input logic [ALU_DATA_WIDTH-1:0] b
    );
        alu_add_req_t r;
        r.a = alu_sext(a);
        if (op == ALU_OP_ADD) begin
            r.b   = alu_sext(b);
            r.cin = 1'b0;
        end else begin
            r.b   = ~alu_sext(b);
            r.cin = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_11_bits_full_adder.sv
// Single-bit full adder cell; one cell per bit of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term is shared between sum and carry.
    always_comb begin
        p    = a ^ b;
        s    = p ^ cin;
        cout = (a & b) | (cin & p);
    end

endmodule

// File: rtl/adder_11_bits.sv
// Registered WIDTH-bit ripple-carry adder with carry-in and carry-out.
// Result {cout, sum} = a + b + cin appears one clock after the operands.
module adder_11_bits
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // carry[0] is the external carry-in; carry[WIDTH] leaves the top cell.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_comb;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (carry[i]),
                .s    (s_comb[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    // Output registers power up cleared so downstream simulation never sees X
    // before the first edge.
    logic [WIDTH-1:0] sum_q  = '0;
    logic             cout_q = 1'b0;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    // Next-state: capture the ripple result every cycle, no enable.
    always_comb begin
        sum_d  = s_comb;
        cout_d = carry[WIDTH];
    end

    // Result register with synchronous clear; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder_11_bits.sv
// Self-checking bench for adder_11_bits against a plain-arithmetic model.
module tb_adder_11_bits;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    int total = 0;
    int bad   = 0;

    adder_11_bits #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Reference: full-precision integer sum, split into carry and wrapped sum.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
        int unsigned t;
        t = int'(ma) + int'(mb) + int'(mc);
        return t[W:0];
    endfunction

    // Drive on the falling edge, then advance past the next rising edge.
    task automatic drive_and_clock(input logic [W-1:0] da, input logic [W-1:0] db,
                                   input logic dc, input logic dr);
        @(negedge clk);
        a = da; b = db; cin = dc; reset = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W:0] exp;
        // power-up value before any edge
        #1;
        total++;
        if ({cout, sum} !== {1'b0, 11'h000}) begin
            bad++;
            $display("FAIL powerup: got cout=%b sum=%h want cout=0 sum=000", cout, sum);
        end
        drive_and_clock(11'h3FF, 11'h155, 1'b1, 1'b1);
        total++;
        if ({cout, sum} !== {1'b0, 11'h000}) begin
            bad++;
            $display("FAIL reset_clear: got cout=%b sum=%h want cout=0 sum=000", cout, sum);
        end
        exp = model(11'h3FF, 11'h155, 1'b1);
        drive_and_clock(11'h3FF, 11'h155, 1'b1, 1'b0);
        total++;
        if ({cout, sum} !== exp) begin
            bad++;
            $display("FAIL reset_release: got cout=%b sum=%h want cout=%b sum=%h",
                     cout, sum, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_add();
        drive_and_clock(11'd0, 11'd0, 1'b0, 1'b0);
        @(negedge clk);
        a = 11'd5; b = 11'd3; cin = 1'b0;
        #1;
        total++;
        if ({cout, sum} !== {1'b0, 11'd0}) begin
            bad++;
            $display("FAIL add_not_early: got cout=%b sum=%h want cout=0 sum=000", cout, sum);
        end
        @(posedge clk);
        #1;
        total++;
        if ({cout, sum} !== {1'b0, 11'd8}) begin
            bad++;
            $display("FAIL add_5_3: got cout=%b sum=%h want cout=0 sum=008", cout, sum);
        end
    endtask

    task automatic test_sub();
        drive_and_clock(11'd5, 11'h7FC, 1'b1, 1'b0);
        total++;
        if ({cout, sum} !== {1'b1, 11'd2}) begin
            bad++;
            $display("FAIL sub_5_3: got cout=%b sum=%h want cout=1 sum=002", cout, sum);
        end
        drive_and_clock(11'd3, 11'h7FA, 1'b1, 1'b0);
        total++;
        if ({cout, sum} !== {1'b0, 11'h7FE}) begin
            bad++;
            $display("FAIL sub_3_5: got cout=%b sum=%h want cout=0 sum=7fe", cout, sum);
        end
    endtask

    task automatic test_boundary();
        drive_and_clock(11'h7FF, 11'h001, 1'b0, 1'b0);
        total++;
        if ({cout, sum} !== {1'b1, 11'h000}) begin
            bad++;
            $display("FAIL wrap_7ff_1: got cout=%b sum=%h want cout=1 sum=000", cout, sum);
        end
        drive_and_clock(11'h7FF, 11'h7FF, 1'b1, 1'b0);
        total++;
        if ({cout, sum} !== {1'b1, 11'h7FF}) begin
            bad++;
            $display("FAIL max_all: got cout=%b sum=%h want cout=1 sum=7ff", cout, sum);
        end
        drive_and_clock(11'h000, 11'h000, 1'b0, 1'b0);
        total++;
        if ({cout, sum} !== {1'b0, 11'h000}) begin
            bad++;
            $display("FAIL zero: got cout=%b sum=%h want cout=0 sum=000", cout, sum);
        end
        // carry-in alone ripples through an all-ones operand
        drive_and_clock(11'h7FF, 11'h000, 1'b1, 1'b0);
        total++;
        if ({cout, sum} !== {1'b1, 11'h000}) begin
            bad++;
            $display("FAIL cin_ripple: got cout=%b sum=%h want cout=1 sum=000", cout, sum);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ra, rb;
        logic         rc, rr;
        logic [W:0]   exp;
        int           errs;
        errs = 0;
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rr = (n == 400 || n == 777) ? 1'b1 : 1'b0;
            exp = rr ? '0 : model(ra, rb, rc);
            drive_and_clock(ra, rb, rc, rr);
            total++;
            if ({cout, sum} !== exp) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL b2b[%0d]: a=%h b=%h cin=%b rst=%b got cout=%b sum=%h want cout=%b sum=%h",
                             n, ra, rb, rc, rr, cout, sum, exp[W], exp[W-1:0]);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_boundary();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
